// File: rtl/hash_table_pkg.sv
// Shared types for the IP hash table controller and its request front end.
package hash_table_pkg;

  localparam int HT_TAG_W = 4;

  typedef enum logic {
    IP_REQ_LOOKUP = 1'b0,
    IP_REQ_INSERT = 1'b1
  } ip_req_op_t;

  typedef struct packed {
    logic [HT_TAG_W-1:0] tag;
    logic                found;
  } ip_lookup_resp_t;

endpackage

// File: rtl/data_valid_if.sv
// Minimal valid + data bundle used for single-direction responses without backpressure.
interface data_valid_if #(
  parameter int DATA_W = 1
) ();

  logic              valid;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data);
  modport slave  (input valid, input data);

endinterface

// File: rtl/data_status_shift_reg.sv
// Fixed-depth shift register carrying a status word alongside a data word.
module data_status_shift_reg #(
  parameter int STATUS_W = 1,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [STATUS_W-1:0] status_i,
  input  logic [DATA_W-1:0]   data_i,
  output logic [STATUS_W-1:0] status_o,
  output logic [DATA_W-1:0]   data_o
);

  logic [STATUS_W-1:0] status_q [DEPTH];
  logic [DATA_W-1:0]   data_q   [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        status_q[i] <= '0;
        data_q[i]   <= '0;
      end
    end else begin
      status_q[0] <= status_i;
      data_q[0]   <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        status_q[i] <= status_q[i-1];
        data_q[i]   <= data_q[i-1];
      end
    end
  end

  assign status_o = status_q[DEPTH-1];
  assign data_o   = data_q[DEPTH-1];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word fall-through FIFO; DEPTH must be a power of 2, at least 2.
module sync_fifo_fwft #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              full;
  logic              do_push;
  logic              do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/ip_lookup_requester.sv
// Request front end for the IP hash controller: issues inserts/look-ups, spaces inserts,
// and re-tags the fixed-latency look-up responses into a credit-protected response FIFO.
module ip_lookup_requester
  import hash_table_pkg::*;
#(
  parameter int IP_ADDR_W  = 32,
  parameter int TAG_W      = 4,
  parameter int CTRL_LAT   = 2,
  parameter int INS_GAP    = 3,
  parameter int RESP_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  ip_req_op_t           req_op_i,
  input  logic [IP_ADDR_W-1:0] req_ip_i,
  input  logic [TAG_W-1:0]     req_tag_i,
  output logic                 insert_val_o,
  output logic                 look_up_val_o,
  output logic [IP_ADDR_W-1:0] ip_addr_o,
  data_valid_if.slave          found_if_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [TAG_W-1:0]     resp_tag_o,
  output logic                 resp_found_o,
  output logic                 err_o
);

  localparam logic [0:0] ST_ISSUE    = 1'b0;
  localparam logic [0:0] ST_INS_HOLD = 1'b1;
  localparam int GAP_W  = (INS_GAP > 1) ? $clog2(INS_GAP) : 1;
  localparam int CRED_W = $clog2(RESP_DEPTH) + 1;

  logic [0:0]           state_q, state_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [CRED_W-1:0]    credits_q, credits_d;
  logic                 run_q;
  logic                 insert_val_q, insert_val_d;
  logic                 look_up_val_q, look_up_val_d;
  logic [IP_ADDR_W-1:0] ip_addr_q, ip_addr_d;
  logic                 err_q, err_d;

  logic                 accept;
  logic                 lu_acc;
  logic                 ins_acc;
  logic                 exp_vld;
  logic [TAG_W-1:0]     exp_tag;
  logic                 resp_push;
  logic                 resp_pop;
  logic                 slot_missed;
  logic                 fifo_empty;
  logic [TAG_W:0]       fifo_dout;

  // run_q holds ready low while reset is asserted, even though the FSM sits in ISSUE.
  always_comb begin
    req_ready_o = 1'b0;
    if (run_q && (state_q == ST_ISSUE))
      req_ready_o = (credits_q < CRED_W'(RESP_DEPTH)) || (req_op_i == IP_REQ_INSERT);
  end

  assign accept      = req_valid_i && req_ready_o;
  assign lu_acc      = accept && (req_op_i == IP_REQ_LOOKUP);
  assign ins_acc     = accept && (req_op_i == IP_REQ_INSERT);
  assign resp_push   = found_if_i.valid && exp_vld;
  assign slot_missed = exp_vld && !found_if_i.valid;
  assign resp_pop    = resp_valid_o && resp_ready_i;

  always_comb begin
    state_d       = state_q;
    gap_cnt_d     = gap_cnt_q;
    insert_val_d  = ins_acc;
    look_up_val_d = lu_acc;
    ip_addr_d     = accept ? req_ip_i : ip_addr_q;
    err_d         = err_q || (found_if_i.valid && !exp_vld) || slot_missed;
    credits_d     = credits_q + CRED_W'(lu_acc) - CRED_W'(resp_pop) - CRED_W'(slot_missed);
    case (state_q)
      ST_ISSUE: begin
        if (ins_acc) begin
          state_d   = ST_INS_HOLD;
          gap_cnt_d = GAP_W'(INS_GAP - 1);
        end
      end
      default: begin
        // ip_addr stays frozen here: the controller writes from its live address input.
        if (gap_cnt_q == '0) state_d = ST_ISSUE;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_ISSUE;
      gap_cnt_q     <= '0;
      credits_q     <= '0;
      run_q         <= 1'b0;
      insert_val_q  <= 1'b0;
      look_up_val_q <= 1'b0;
      ip_addr_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_cnt_q     <= gap_cnt_d;
      credits_q     <= credits_d;
      run_q         <= 1'b1;
      insert_val_q  <= insert_val_d;
      look_up_val_q <= look_up_val_d;
      ip_addr_q     <= ip_addr_d;
      err_q         <= err_d;
    end
  end

  assign insert_val_o  = insert_val_q;
  assign look_up_val_o = look_up_val_q;
  assign ip_addr_o     = ip_addr_q;
  assign err_o         = err_q;

  // Stage CTRL_LAT of the pipe lines up with the controller's found_valid for the same look-up.
  data_status_shift_reg #(
    .STATUS_W (1),
    .DATA_W   (TAG_W),
    .DEPTH    (CTRL_LAT + 1)
  ) u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst),
    .status_i (lu_acc),
    .data_i   (req_tag_i),
    .status_o (exp_vld),
    .data_o   (exp_tag)
  );

  sync_fifo_fwft #(
    .DATA_W (TAG_W + 1),
    .DEPTH  (RESP_DEPTH)
  ) u_resp_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (resp_push),
    .din_i   ({exp_tag, found_if_i.data[0]}),
    .pop_i   (resp_pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty)
  );

  assign resp_valid_o = !fifo_empty;
  assign resp_tag_o   = resp_valid_o ? fifo_dout[TAG_W:1] : '0;
  assign resp_found_o = resp_valid_o ? fifo_dout[0] : 1'b0;

endmodule
